// File: rtl/alu_rr_sequencer_pkg.sv
// Shared types and constants for the register-register ALU control-step sequencer:
// control-step states, opcode and ALUop encodings, and the opcode decode helpers.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6
   } state_t;

   localparam int unsigned OPC_ADD  = 3;
   localparam int unsigned OPC_SUB  = 4;
   localparam int unsigned OPC_AND  = 5;
   localparam int unsigned OPC_OR   = 6;
   localparam int unsigned OPC_ROR  = 7;
   localparam int unsigned OPC_ROL  = 8;
   localparam int unsigned OPC_SHR  = 9;
   localparam int unsigned OPC_SHRA = 10;
   localparam int unsigned OPC_SHL  = 11;
   localparam int unsigned OPC_MUL  = 15;
   localparam int unsigned OPC_DIV  = 16;

   localparam logic [3:0] ALUOP_NONE = 4'd0;
   localparam logic [3:0] ALUOP_ADD  = 4'd1;
   localparam logic [3:0] ALUOP_SUB  = 4'd2;
   localparam logic [3:0] ALUOP_AND  = 4'd3;
   localparam logic [3:0] ALUOP_OR   = 4'd4;
   localparam logic [3:0] ALUOP_SHR  = 4'd5;
   localparam logic [3:0] ALUOP_SHRA = 4'd6;
   localparam logic [3:0] ALUOP_SHL  = 4'd7;
   localparam logic [3:0] ALUOP_ROR  = 4'd8;
   localparam logic [3:0] ALUOP_ROL  = 4'd9;

   // Wide ops and undecodable opcodes both map to ALUOP_NONE.
   function automatic logic [3:0] aluop_map(input int unsigned op);
      case (op)
         OPC_ADD:  return ALUOP_ADD;
         OPC_SUB:  return ALUOP_SUB;
         OPC_AND:  return ALUOP_AND;
         OPC_OR:   return ALUOP_OR;
         OPC_ROR:  return ALUOP_ROR;
         OPC_ROL:  return ALUOP_ROL;
         OPC_SHR:  return ALUOP_SHR;
         OPC_SHRA: return ALUOP_SHRA;
         OPC_SHL:  return ALUOP_SHL;
         default:  return ALUOP_NONE;
      endcase
   endfunction

   function automatic logic is_legal_op(input int unsigned op);
      return (aluop_map(op) != ALUOP_NONE) || (op == OPC_MUL) || (op == OPC_DIV);
   endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Handshake and datapath-control bundle between the sequencer (master) and the
// datapath it steers (slave).
interface alu_rr_sequencer_if #(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 32,
   parameter int ALUOP_W  = 4
);
   logic                start;
   logic                mem_ready;
   logic [DATA_W-1:0]   ir;

   logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
   logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
   logic [NUM_REGS-1:0] Rin;
   logic [NUM_REGS-1:0] Rout;
   logic [ALUOP_W-1:0]  ALUop;
   logic                ALU_MUL, ALU_DIV;
   logic                busy, done, illegal;

   modport master (
      input  start, mem_ready, ir,
      output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
      output Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
      output Rin, Rout, ALUop, ALU_MUL, ALU_DIV, busy, done, illegal
   );

   modport slave (
      output start, mem_ready, ir,
      input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
      input  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
      input  Rin, Rout, ALUop, ALU_MUL, ALU_DIV, busy, done, illegal
   );
endinterface

// File: rtl/alu_rr_sequencer_reg_decoder.sv
// Register-index to one-hot enable decoder; all outputs low when not enabled.
module reg_decoder #(
   parameter int NUM_REGS = 16,
   parameter int REG_W    = $clog2(NUM_REGS)
) (
   input  logic                en_i,
   input  logic [REG_W-1:0]    idx_i,
   output logic [NUM_REGS-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         onehot_o[i] = en_i && (idx_i == REG_W'(i));
      end
   end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Hardwired fetch/execute control-step sequencer for register-register ALU
// instructions, including MUL/DIV with HI/LO writeback and a memory-ready wait.
module alu_rr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 32,
   parameter int OP_W     = 5,
   parameter int ALUOP_W  = 4
) (
   input logic clock,
   input logic clear,
   alu_rr_sequencer_if.master bus
);

   localparam int REG_W = $clog2(NUM_REGS);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   opcode_q, opcode_d;
   logic [REG_W-1:0]  ra_q, ra_d;
   logic [REG_W-1:0]  rc_q, rc_d;

   logic [OP_W-1:0]   irOpcode;
   logic [REG_W-1:0]  irRa, irRb, irRc;
   logic              irLegal;
   logic              isMul, isDiv;
   logic              routEn, rinEn;
   logic [REG_W-1:0]  routIdx;

   assign irOpcode = bus.ir[DATA_W-1 -: OP_W];
   assign irRa     = bus.ir[DATA_W-OP_W-1 -: REG_W];
   assign irRb     = bus.ir[DATA_W-OP_W-REG_W-1 -: REG_W];
   assign irRc     = bus.ir[DATA_W-OP_W-2*REG_W-1 -: REG_W];
   assign irLegal  = is_legal_op(32'(irOpcode));
   assign isMul    = (32'(opcode_q) == OPC_MUL);
   assign isDiv    = (32'(opcode_q) == OPC_DIV);

   // Clear wins over everything, including a chaining start in the final step.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
         ra_q     <= '0;
         rc_q     <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         ra_q     <= ra_d;
         rc_q     <= rc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      ra_d         = ra_q;
      rc_d         = rc_q;
      routEn       = 1'b0;
      routIdx      = '0;
      rinEn        = 1'b0;
      bus.PCout    = 1'b0;
      bus.MARin    = 1'b0;
      bus.IncPC    = 1'b0;
      bus.PCin     = 1'b0;
      bus.Read     = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zlowin   = 1'b0;
      bus.Zhighin  = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.ALUop    = '0;
      bus.ALU_MUL  = 1'b0;
      bus.ALU_DIV  = 1'b0;
      bus.busy     = (state_q != S_IDLE);
      bus.done     = 1'b0;
      bus.illegal  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_T0;
         end
         S_T0: begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPC  = 1'b1;
            bus.Zlowin = 1'b1;
            state_d    = S_T1;
         end
         // Read is held while memory is slow; PC update and MDR load only land with data.
         S_T1: begin
            bus.Read = 1'b1;
            if (bus.mem_ready) begin
               bus.Zlowout = 1'b1;
               bus.PCin    = 1'b1;
               bus.MDRin   = 1'b1;
               state_d     = S_T2;
            end
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_d    = S_T3;
         end
         S_T3: begin
            if (irLegal) begin
               routEn   = 1'b1;
               routIdx  = irRb;
               bus.Yin  = 1'b1;
               opcode_d = irOpcode;
               ra_d     = irRa;
               rc_d     = irRc;
               state_d  = S_T4;
            end else begin
               bus.illegal = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_T4: begin
            routEn     = 1'b1;
            routIdx    = rc_q;
            bus.Zlowin = 1'b1;
            if (isMul || isDiv) begin
               bus.Zhighin = 1'b1;
               bus.ALU_MUL = isMul;
               bus.ALU_DIV = isDiv;
            end else begin
               bus.ALUop = ALUOP_W'(aluop_map(32'(opcode_q)));
            end
            state_d = S_T5;
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            if (isMul || isDiv) begin
               bus.LOin = 1'b1;
               state_d  = S_T6;
            end else begin
               rinEn    = 1'b1;
               bus.done = 1'b1;
               state_d  = bus.start ? S_T0 : S_IDLE;
            end
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            bus.done     = 1'b1;
            state_d      = bus.start ? S_T0 : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   reg_decoder #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_routDec (
      .en_i     (routEn),
      .idx_i    (routIdx),
      .onehot_o (bus.Rout)
   );

   reg_decoder #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_rinDec (
      .en_i     (rinEn),
      .idx_i    (ra_q),
      .onehot_o (bus.Rin)
   );

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench: hand-computed instruction table, clear/back-to-back corner
// sequences, and random instructions against a per-step behavioural model.
module tb_alu_rr_sequencer;

   typedef struct packed {
      logic busy, done, illegal;
      logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
      logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
      logic aluMul, aluDiv;
      logic [3:0]  aluop;
      logic [15:0] rin, rout;
   } ctl_t;

   typedef struct {
      string       name;
      logic [31:0] ir;
      int          waits;
      int          expLat;
      logic [15:0] expRoutB, expRoutC, expRin;
      logic [3:0]  expAluop;
      logic [1:0]  expWide;
      bit          expIllegal;
   } vec_t;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   alu_rr_sequencer_if #(.NUM_REGS(16), .DATA_W(32), .ALUOP_W(4)) bus();

   alu_rr_sequencer #(.NUM_REGS(16), .DATA_W(32), .OP_W(5), .ALUOP_W(4)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   int nCompared = 0;
   int nMismatched = 0;
   int cycIdx, doneAt, illegalAt;
   logic [15:0] capRoutB, capRoutC, capRin;
   logic [3:0]  capAluop;
   logic [1:0]  capWide;
   ctl_t expQ[$];

   function automatic ctl_t observe();
      ctl_t c;
      c.busy = bus.busy; c.done = bus.done; c.illegal = bus.illegal;
      c.PCout = bus.PCout; c.MARin = bus.MARin; c.IncPC = bus.IncPC; c.PCin = bus.PCin;
      c.Read = bus.Read; c.MDRin = bus.MDRin; c.MDRout = bus.MDRout; c.IRin = bus.IRin;
      c.Yin = bus.Yin; c.Zlowin = bus.Zlowin; c.Zhighin = bus.Zhighin;
      c.Zlowout = bus.Zlowout; c.Zhighout = bus.Zhighout; c.HIin = bus.HIin; c.LOin = bus.LOin;
      c.aluMul = bus.ALU_MUL; c.aluDiv = bus.ALU_DIV; c.aluop = bus.ALUop;
      c.rin = bus.Rin; c.rout = bus.Rout;
      return c;
   endfunction

   function automatic void decodeOp(input int op, output bit legal, output bit mul,
                                    output bit div, output logic [3:0] aop);
      legal = 1'b1; mul = 1'b0; div = 1'b0; aop = 4'd0;
      case (op)
         3: aop = 4'd1;  4: aop = 4'd2;  5: aop = 4'd3;  6: aop = 4'd4;
         7: aop = 4'd8;  8: aop = 4'd9;  9: aop = 4'd5; 10: aop = 4'd6; 11: aop = 4'd7;
         15: mul = 1'b1;
         16: div = 1'b1;
         default: legal = 1'b0;
      endcase
   endfunction

   // One record per cycle from T0 to the final step, derived from the instruction's meaning.
   function automatic void buildExpect(input logic [31:0] irv, input int waits);
      ctl_t c;
      bit legal, mul, div;
      logic [3:0] aop;
      int op = int'(irv[31:27]);
      int ra = int'(irv[26:23]);
      int rb = int'(irv[22:19]);
      int rc = int'(irv[18:15]);
      decodeOp(op, legal, mul, div, aop);
      expQ.delete();
      c = '0; c.busy = 1; c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zlowin = 1; expQ.push_back(c);
      for (int w = 0; w < waits; w++) begin
         c = '0; c.busy = 1; c.Read = 1; expQ.push_back(c);
      end
      c = '0; c.busy = 1; c.Read = 1; c.Zlowout = 1; c.PCin = 1; c.MDRin = 1; expQ.push_back(c);
      c = '0; c.busy = 1; c.MDRout = 1; c.IRin = 1; expQ.push_back(c);
      if (!legal) begin
         c = '0; c.busy = 1; c.illegal = 1; expQ.push_back(c);
         return;
      end
      c = '0; c.busy = 1; c.Yin = 1; c.rout = 16'd1 << rb; expQ.push_back(c);
      c = '0; c.busy = 1; c.Zlowin = 1; c.rout = 16'd1 << rc;
      if (mul || div) begin
         c.Zhighin = 1; c.aluMul = mul; c.aluDiv = div;
      end else begin
         c.aluop = aop;
      end
      expQ.push_back(c);
      if (mul || div) begin
         c = '0; c.busy = 1; c.Zlowout = 1; c.LOin = 1; expQ.push_back(c);
         c = '0; c.busy = 1; c.Zhighout = 1; c.HIin = 1; c.done = 1; expQ.push_back(c);
      end else begin
         c = '0; c.busy = 1; c.Zlowout = 1; c.rin = 16'd1 << ra; c.done = 1; expQ.push_back(c);
      end
   endfunction

   task automatic applyStimulus(input logic startV, input logic memV,
                                input logic [31:0] irV, input logic clearV);
      bus.start     = startV;
      bus.mem_ready = memV;
      bus.ir        = irV;
      clear         = clearV;
   endtask

   task automatic checkOutput(input string name, input ctl_t exp);
      ctl_t act;
      act = observe();
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycIdx, act, exp);
      end
      if (act.Yin) capRoutB = act.rout;
      if (act.Zlowin && !act.PCout) begin
         capRoutC = act.rout;
         capAluop = act.aluop;
         capWide  = {act.aluMul, act.aluDiv};
      end
      if (act.done) begin
         doneAt = cycIdx;
         capRin = act.rin;
      end
      if (act.illegal) illegalAt = cycIdx;
   endtask

   task automatic checkVal(input string name, input int act, input int exp);
      nCompared++;
      if (act != exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input string name, input ctl_t exp, input logic startV,
                       input logic memV, input logic [31:0] irV, input logic clearV);
      @(negedge clock);
      applyStimulus(startV, memV, irV, clearV);
      #1;
      checkOutput(name, exp);
   endtask

   task automatic idle(input string name, input logic startV);
      cycIdx = 0;
      step(name, '0, startV, 1'b1, $urandom, 1'b0);
   endtask

   // Drives one instruction from T0; clearAt >= 0 asserts clear in that step and stops.
   task automatic runSeq(input string name, input logic [31:0] irv, input int waits,
                         input bit startAtEnd, input int clearAt);
      ctl_t e;
      logic [31:0] irNow;
      logic memV, startV;
      bit decoded;
      int n;
      buildExpect(irv, waits);
      n = expQ.size();
      irNow = irv;
      decoded = 0;
      capRoutB = '0; capRoutC = '0; capRin = '0; capAluop = '0; capWide = '0;
      doneAt = -1; illegalAt = -1;
      for (int i = 0; i < n; i++) begin
         e = expQ[i];
         cycIdx = i + 1;
         if (decoded) irNow = $urandom;
         memV = (e.Read && !e.MDRin) ? 1'b0 : (e.Read ? 1'b1 : 1'($urandom));
         startV = (i == n - 1) ? startAtEnd : 1'($urandom);
         step(name, e, startV, memV, irNow, clearAt == i);
         if (e.Yin || e.illegal) decoded = 1;
         if (clearAt == i) break;
      end
   endtask

   initial begin
      vec_t vecs[10];
      int legalOps[11] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16};
      int illegalOps[10] = '{0, 1, 2, 12, 13, 14, 17, 20, 25, 31};
      bit chain;

      vecs[0] = '{"rol",      32'h43820000, 0, 6, 16'h0001, 16'h0010, 16'h0080, 4'd9, 2'b00, 1'b0};
      vecs[1] = '{"mul",      32'h781A8000, 0, 7, 16'h0008, 16'h0020, 16'h0000, 4'd0, 2'b10, 1'b0};
      vecs[2] = '{"rolWait",  32'h43820000, 3, 9, 16'h0001, 16'h0010, 16'h0080, 4'd9, 2'b00, 1'b0};
      vecs[3] = '{"illF8",    32'hF8000000, 0, 4, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b1};
      vecs[4] = '{"div",      32'h81488000, 0, 7, 16'h0200, 16'h0002, 16'h0000, 4'd0, 2'b01, 1'b0};
      vecs[5] = '{"shraSame", 32'h57FF8000, 0, 6, 16'h8000, 16'h8000, 16'h8000, 4'd6, 2'b00, 1'b0};
      vecs[6] = '{"subR0",    32'h20000000, 1, 7, 16'h0001, 16'h0001, 16'h0001, 4'd2, 2'b00, 1'b0};
      vecs[7] = '{"illOp0",   32'h00000000, 0, 4, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b1};
      vecs[8] = '{"illOp12",  32'h60000000, 0, 4, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 1'b1};
      vecs[9] = '{"ror",      32'h38890000, 0, 6, 16'h0002, 16'h0004, 16'h0002, 4'd8, 2'b00, 1'b0};

      cycIdx = 0;
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
      repeat (2) @(posedge clock);
      step("reset", '0, 1'b1, 1'b1, 32'h0, 1'b1);
      step("resetRelease", '0, 1'b0, 1'b1, 32'h0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         idle({vecs[i].name, "Start"}, 1'b1);
         runSeq(vecs[i].name, vecs[i].ir, vecs[i].waits, 1'b0, -1);
         checkVal({vecs[i].name, "Latency"}, vecs[i].expIllegal ? illegalAt : doneAt, vecs[i].expLat);
         checkVal({vecs[i].name, "Illegal"}, int'(illegalAt != -1), int'(vecs[i].expIllegal));
         checkVal({vecs[i].name, "RoutT3"}, int'(capRoutB), int'(vecs[i].expRoutB));
         checkVal({vecs[i].name, "RoutT4"}, int'(capRoutC), int'(vecs[i].expRoutC));
         checkVal({vecs[i].name, "RinDone"}, int'(capRin), int'(vecs[i].expRin));
         checkVal({vecs[i].name, "AluOp"}, int'(capAluop), int'(vecs[i].expAluop));
         checkVal({vecs[i].name, "Wide"}, int'(capWide), int'(vecs[i].expWide));
      end
      idle("afterTable", 1'b0);

      idle("b2bStart", 1'b1);
      runSeq("b2bFirst", 32'h18918000, 0, 1'b1, -1);
      checkVal("b2bFirstDone", doneAt, 6);
      runSeq("b2bSecond", 32'h18918000, 0, 1'b0, -1);
      checkVal("b2bSecondDone", doneAt, 6);
      idle("b2bIdle", 1'b0);

      idle("clrT4Start", 1'b1);
      runSeq("clrT4", 32'h43820000, 0, 1'b0, 4);
      idle("clrT4After", 1'b0);
      idle("postClrStart", 1'b1);
      runSeq("postClr", 32'h43820000, 0, 1'b0, -1);
      checkVal("postClrDone", doneAt, 6);

      idle("clrWaitStart", 1'b1);
      runSeq("clrWait", 32'h43820000, 3, 1'b0, 2);
      idle("clrWaitAfter", 1'b0);

      idle("clrFinalStart", 1'b1);
      runSeq("clrFinal", 32'h781A8000, 0, 1'b1, 6);
      idle("clrFinalAfter", 1'b0);

      chain = 0;
      for (int r = 0; r < 40; r++) begin
         int op;
         int waits;
         bit nextChain;
         bit legal, mul, div;
         logic [3:0] aop;
         logic [31:0] irv;
         if ($urandom_range(0, 7) == 0) op = illegalOps[$urandom_range(0, 9)];
         else op = legalOps[$urandom_range(0, 10)];
         irv = {5'(op), 27'($urandom)};
         waits = $urandom_range(0, 3);
         nextChain = 1'($urandom);
         decodeOp(op, legal, mul, div, aop);
         if (!chain) begin
            repeat ($urandom_range(0, 2)) idle("rndIdle", 1'b0);
            idle("rndStart", 1'b1);
         end
         runSeq("rnd", irv, waits, nextChain, -1);
         chain = nextChain && legal;
      end
      if (chain) runSeq("rndTail", 32'h18918000, 0, 1'b0, -1);
      idle("finalIdle", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
